// File: rtl/cache_refill_if.sv
// Bus bundle for the cache line-refill engine.
//   miss side  : miss_req, miss_addr (from cache controller); busy, done back
//   RAM side   : ram_rd, ram_addr out; ram_ack, ram_data in
//   array side : cache_wr, cache_line, cache_blk, cache_din, tag_wr, tag_out
// master = refill engine, slave = surrounding cache controller / RAM / arrays.
interface cache_refill_if;
   logic        miss_req;
   logic [10:0] miss_addr;
   logic        busy;
   logic        done;
   logic        ram_rd;
   logic [10:0] ram_addr;
   logic        ram_ack;
   logic [7:0]  ram_data;
   logic        cache_wr;
   logic [1:0]  cache_line;
   logic [2:0]  cache_blk;
   logic [7:0]  cache_din;
   logic        tag_wr;
   logic [5:0]  tag_out;

   modport master (
      input  miss_req, miss_addr, ram_ack, ram_data,
      output busy, done, ram_rd, ram_addr,
             cache_wr, cache_line, cache_blk, cache_din, tag_wr, tag_out
   );

   modport slave (
      output miss_req, miss_addr, ram_ack, ram_data,
      input  busy, done, ram_rd, ram_addr,
             cache_wr, cache_line, cache_blk, cache_din, tag_wr, tag_out
   );
endinterface

// File: rtl/cache_refill.sv
// Line-refill engine for a 4-line, 8-byte-block, read-only direct-mapped cache.
// On a miss it reads the 8 bytes of the block from RAM (req/ack handshake),
// writes each into the data array, then strobes the tag/valid write and done.
// Address layout: tag[10:5], line[4:3], blk[2:0].
// Ports: clk, reset (synchronous, active high), bus (cache_refill_if.master).
// Build option: CACHE_REFILL_CRIT_FIRST_EN -- when defined, the fetch starts
// at the missing byte and wraps; otherwise it always starts at byte 0.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for miss_req
// ST_REQ   | ram_rd high, waiting for ram_ack
// ST_WRITE | one-cycle data-array write of the fetched byte
// ST_DONE  | one-cycle done + tag write
module cache_refill (
   input  logic          clk,
   input  logic          reset,
   cache_refill_if.master bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WRITE, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  tag_q,   tag_d;
   logic [1:0]  line_q,  line_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic [3:0]  word_q,  word_d;
   logic [7:0]  din_q,   din_d;
   logic [2:0]  start_idx;

`ifdef CACHE_REFILL_CRIT_FIRST_EN
   assign start_idx = bus.miss_addr[2:0];
`else
   assign start_idx = 3'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tag_q   <= '0;
         line_q  <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         din_q   <= din_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      din_d   = din_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.miss_req) begin
               tag_d   = bus.miss_addr[10:5];
               line_d  = bus.miss_addr[4:3];
               cnt_d   = start_idx;
               word_d  = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.ram_ack) begin
               din_d   = bus.ram_data;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // cnt wraps 7 -> 0 naturally; word counter decides completion
            cnt_d   = cnt_q + 3'd1;
            word_d  = word_q + 4'd1;
            state_d = (word_q == 4'd7) ? ST_DONE : ST_REQ;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.tag_wr     = (state_q == ST_DONE);
   assign bus.ram_rd     = (state_q == ST_REQ);
   assign bus.cache_wr   = (state_q == ST_WRITE);
   assign bus.ram_addr   = {tag_q, line_q, cnt_q};
   assign bus.cache_line = line_q;
   assign bus.cache_blk  = cnt_q;
   assign bus.cache_din  = din_q;
   assign bus.tag_out    = tag_q;
endmodule
